// File: rtl/read_ctrl_multi.sv
// read_ctrl_multi: read-side controller for an N-buffer round-robin buffer memory.
// On a read request it checks the current buffer's full flag, then either bursts
// every word of that buffer out of a 1-cycle-latency sync RAM and releases the
// buffer to the writer, or reports an error and skips the empty buffer.
// Optional feature macro: READ_CTRL_ERR_CNT_EN adds an 8-bit saturating error
// counter on output err_cnt_o.
module read_ctrl_multi #(
  parameter  int DATA_W    = 8,
  parameter  int NUM_BUF   = 2,
  parameter  int BUF_DEPTH = 4,
  localparam int BW        = $clog2(NUM_BUF),
  localparam int WW        = $clog2(BUF_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 read_i,
  input  logic [NUM_BUF-1:0]   status_vld_i,
  input  logic [DATA_W-1:0]    r_data_i,
  output logic                 r_en_o,
  output logic [BW+WW-1:0]     r_addr_o,
  output logic [DATA_W-1:0]    dout_o,
  output logic                 dout_vld_o,
  output logic                 dout_last_o,
  output logic                 dout_err_o,
  output logic [NUM_BUF-1:0]   r_done_o,
  output logic                 busy_o,
  output logic [BW-1:0]        cur_buf_o
`ifdef READ_CTRL_ERR_CNT_EN
  ,
  output logic [7:0]           err_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, RD, DRAIN, ERR} state_t;

  localparam logic [WW-1:0] LAST_WORD = WW'(BUF_DEPTH - 1);
  localparam logic [BW-1:0] LAST_BUF  = BW'(NUM_BUF - 1);

  state_t               state_q;
  logic [WW-1:0]        word_q;
  logic [BW-1:0]        cur_buf_q;
  logic [BW-1:0]        cur_buf_d;
  logic [NUM_BUF-1:0]   done_d;
  logic                 r_en_q;
  logic [BW+WW-1:0]     r_addr_q;
  logic                 rvld_q;
  logic                 rlast_q;
  logic [DATA_W-1:0]    dout_q;
  logic                 dout_vld_q;
  logic                 dout_last_q;
  logic                 dout_err_q;
  logic [NUM_BUF-1:0]   r_done_q;
  logic                 busy_q;

  // Next buffer index with an explicit wrap so NUM_BUF need not be a power of two.
  always_comb begin
    cur_buf_d = cur_buf_q + BW'(1);
    if (cur_buf_q == LAST_BUF) begin
      cur_buf_d = '0;
    end
  end

  // One-hot release pattern for the buffer currently being read.
  always_comb begin
    done_d            = '0;
    done_d[cur_buf_q] = 1'b1;
  end

  // Control FSM plus the two-stage read-data pipeline (RAM latency, then output register).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      word_q      <= '0;
      cur_buf_q   <= '0;
      r_en_q      <= 1'b0;
      r_addr_q    <= '0;
      rvld_q      <= 1'b0;
      rlast_q     <= 1'b0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      dout_last_q <= 1'b0;
      dout_err_q  <= 1'b0;
      r_done_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      rvld_q      <= r_en_q;
      dout_vld_q  <= rvld_q;
      dout_last_q <= rlast_q;
      r_done_q    <= rlast_q ? done_d : '0;
      rlast_q     <= 1'b0;
      dout_err_q  <= 1'b0;
      if (rvld_q) begin
        dout_q <= r_data_i;
      end
      case (state_q)
        IDLE: begin
          if (read_i) begin
            busy_q <= 1'b1;
            if (status_vld_i[cur_buf_q]) begin
              state_q  <= RD;
              r_en_q   <= 1'b1;
              word_q   <= '0;
              r_addr_q <= {cur_buf_q, WW'(0)};
            end else begin
              state_q    <= ERR;
              dout_err_q <= 1'b1;
            end
          end
        end
        RD: begin
          if (word_q == LAST_WORD) begin
            r_en_q  <= 1'b0;
            rlast_q <= 1'b1;
            state_q <= DRAIN;
          end else begin
            word_q   <= word_q + WW'(1);
            r_addr_q <= {cur_buf_q, word_q + WW'(1)};
          end
        end
        DRAIN: begin
          if (dout_last_q) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            cur_buf_q <= cur_buf_d;
          end
        end
        ERR: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          cur_buf_q <= cur_buf_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r_en_o      = r_en_q;
  assign r_addr_o    = r_addr_q;
  assign dout_o      = dout_q;
  assign dout_vld_o  = dout_vld_q;
  assign dout_last_o = dout_last_q;
  assign dout_err_o  = dout_err_q;
  assign r_done_o    = r_done_q;
  assign busy_o      = busy_q;
  assign cur_buf_o   = cur_buf_q;

`ifdef READ_CTRL_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Count error pulses, sticking at all-ones; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (dout_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_read_ctrl_multi.sv
// tb_read_ctrl_multi: scoreboard bench for read_ctrl_multi (DATA_W=8, NUM_BUF=2,
// BUF_DEPTH=4). A transaction-level model predicts every burst, error pulse and
// RAM access when a read is accepted; a monitor compares what the DUT presents.
module tb_read_ctrl_multi;

  logic       clk;
  logic       rst;
  logic       readReq;
  logic [1:0] statusVld;
  logic [7:0] rData;
  logic       rEn;
  logic [2:0] rAddr;
  logic [7:0] dout;
  logic       doutVld;
  logic       doutLast;
  logic       doutErr;
  logic [1:0] rDone;
  logic       busy;
  logic       curBuf;
`ifdef READ_CTRL_ERR_CNT_EN
  logic [7:0] errCnt;
`endif

  read_ctrl_multi #(.DATA_W(8), .NUM_BUF(2), .BUF_DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .read_i       (readReq),
    .status_vld_i (statusVld),
    .r_data_i     (rData),
    .r_en_o       (rEn),
    .r_addr_o     (rAddr),
    .dout_o       (dout),
    .dout_vld_o   (doutVld),
    .dout_last_o  (doutLast),
    .dout_err_o   (doutErr),
    .r_done_o     (rDone),
    .busy_o       (busy),
    .cur_buf_o    (curBuf)
`ifdef READ_CTRL_ERR_CNT_EN
    ,
    .err_cnt_o    (errCnt)
`endif
  );

  typedef struct {
    int         cyc;
    logic       vld;
    logic       last;
    logic       err;
    logic [1:0] done;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [2:0] addr;
  } addr_t;

  exp_t       expQ[$];
  addr_t      addrQ[$];
  int         errVisQ[$];
  int         cyc       = 0;
  int         freeAt    = 0;
  int         busyFrom  = 0;
  int         changeAt  = 0;
  int         mCur      = 0;
  int         prevCur   = 0;
  int         expErrCnt = 0;
  logic [7:0] expLast   = 8'h00;
  bit         monOn     = 0;
  int         nChecks   = 0;
  int         nPass     = 0;

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM stand-in: one cycle latency, contents are address + 0x10.
  always @(posedge clk) begin
    if (rEn) rData <= 8'h10 + {5'd0, rAddr};
    else     rData <= 8'($urandom);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    else nPass++;
  endtask

  task automatic applyStimulus(input logic rd, input logic [1:0] sv, input logic rs, input int n);
    for (int i = 0; i < n; i++) begin
      readReq   = rd;
      statusVld = sv;
      rst       = rs;
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: on each accepted read, predict the whole transaction up front.
  always @(posedge clk) begin
    if (rst) begin
      expQ.delete();
      addrQ.delete();
      errVisQ.delete();
      mCur      = 0;
      prevCur   = 0;
      changeAt  = 0;
      busyFrom  = 0;
      freeAt    = cyc + 1;
      expErrCnt = 0;
      expLast   = 8'h00;
    end else if (readReq && cyc >= freeAt) begin
      if (statusVld[mCur]) begin
        for (int i = 0; i < 4; i++) begin
          addr_t a;
          exp_t  e;
          a.cyc  = cyc + 1 + i;
          a.addr = 3'(mCur * 4 + i);
          addrQ.push_back(a);
          e.cyc  = cyc + 3 + i;
          e.vld  = 1'b1;
          e.last = (i == 3);
          e.err  = 1'b0;
          e.done = (i == 3) ? 2'(1 << mCur) : 2'b00;
          e.data = 8'(8'h10 + mCur * 4 + i);
          expQ.push_back(e);
        end
        freeAt = cyc + 7;
      end else begin
        exp_t e;
        e.cyc  = cyc + 1;
        e.vld  = 1'b0;
        e.last = 1'b0;
        e.err  = 1'b1;
        e.done = 2'b00;
        e.data = 8'h00;
        expQ.push_back(e);
        errVisQ.push_back(cyc + 2);
        freeAt = cyc + 2;
      end
      busyFrom = cyc + 1;
      prevCur  = mCur;
      mCur     = (mCur + 1) % 2;
      changeAt = freeAt;
    end
    cyc++;
  end

  // Monitor: compare DUT outputs against the scoreboard on the falling edge.
  always @(negedge clk) begin
    if (monOn) begin
      exp_t  e;
      addr_t a;
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        checkOutput("out_missing_cycle", cyc, expQ[0].cyc);
        void'(expQ.pop_front());
      end
      if (doutVld || doutLast || doutErr || rDone != 2'b00) begin
        if (expQ.size() == 0) begin
          checkOutput("out_unexpected", {doutVld, doutLast, doutErr, rDone}, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_cycle", cyc, e.cyc);
          checkOutput("dout_vld", doutVld, e.vld);
          checkOutput("dout_last", doutLast, e.last);
          checkOutput("dout_err", doutErr, e.err);
          checkOutput("r_done", rDone, e.done);
          if (e.vld) begin
            checkOutput("dout", dout, e.data);
            expLast = e.data;
          end
        end
      end
      if (!doutVld) checkOutput("dout_hold", dout, expLast);
      while (addrQ.size() > 0 && addrQ[0].cyc < cyc) begin
        checkOutput("r_en_missing_cycle", cyc, addrQ[0].cyc);
        void'(addrQ.pop_front());
      end
      if (rEn) begin
        if (addrQ.size() == 0) begin
          checkOutput("r_en_unexpected", rEn, 0);
        end else begin
          a = addrQ.pop_front();
          checkOutput("r_en_cycle", cyc, a.cyc);
          checkOutput("r_addr", rAddr, a.addr);
        end
      end
      checkOutput("busy", busy, (cyc >= busyFrom && cyc < freeAt));
      checkOutput("cur_buf", curBuf, (cyc >= changeAt) ? mCur : prevCur);
      while (errVisQ.size() > 0 && errVisQ[0] <= cyc) begin
        void'(errVisQ.pop_front());
        if (expErrCnt < 255) expErrCnt++;
      end
`ifdef READ_CTRL_ERR_CNT_EN
      checkOutput("err_cnt", errCnt, expErrCnt);
`endif
    end
  end

  // Stimulus: reset, directed scenarios, randomized traffic, error saturation, drain.
  initial begin
    readReq   = 1'b1;
    statusVld = 2'b11;
    rst       = 1'b1;
    applyStimulus(1'b1, 2'b11, 1'b1, 3);
    @(negedge clk);
    checkOutput("reset_r_en", rEn, 0);
    checkOutput("reset_r_addr", rAddr, 0);
    checkOutput("reset_dout", dout, 0);
    checkOutput("reset_dout_vld", doutVld, 0);
    checkOutput("reset_dout_last", doutLast, 0);
    checkOutput("reset_dout_err", doutErr, 0);
    checkOutput("reset_r_done", rDone, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_cur_buf", curBuf, 0);
    monOn = 1;

    applyStimulus(1'b1, 2'b11, 1'b0, 1);
    applyStimulus(1'b0, 2'b11, 1'b0, 9);
    applyStimulus(1'b1, 2'b11, 1'b0, 1);
    applyStimulus(1'b0, 2'b11, 1'b0, 9);
    applyStimulus(1'b1, 2'b00, 1'b0, 1);
    applyStimulus(1'b0, 2'b00, 1'b0, 4);
    applyStimulus(1'b1, 2'b11, 1'b0, 20);
    applyStimulus(1'b0, 2'b11, 1'b0, 10);

    applyStimulus(1'b1, 2'b11, 1'b0, 1);
    applyStimulus(1'b0, 2'b00, 1'b0, 2);
    applyStimulus(1'b0, 2'b11, 1'b1, 1);
    applyStimulus(1'b1, 2'b11, 1'b0, 1);
    applyStimulus(1'b0, 2'b11, 1'b0, 10);

    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom % 3) == 0, 2'($urandom), ($urandom % 200) == 0, 1);
    end

    applyStimulus(1'b0, 2'b00, 1'b1, 1);
    applyStimulus(1'b1, 2'b00, 1'b0, 650);
    applyStimulus(1'b0, 2'b00, 1'b0, 10);

    @(negedge clk);
    checkOutput("exp_queue_empty", expQ.size(), 0);
    checkOutput("addr_queue_empty", addrQ.size(), 0);
`ifdef READ_CTRL_ERR_CNT_EN
    checkOutput("err_cnt_saturated", errCnt, 8'hFF);
`endif
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
